z_transfer_sequencer: RTL
=========================

Name: z_transfer_sequencer

Overview:
- Control FSM that runs one ALU operation and moves its result through the Z register.
- Handles single-width ops (result to a general register) and 64-bit MUL/DIV (result split to LO/HI).
- Starts a multicycle ALU, waits on its done handshake with a timeout, captures the result into Z one half per cycle, then drives Z onto the bus into the destination registers.
- Sits between the control unit's instruction decode and the datapath (ALU, Z, LO, HI, register file).

Parameters:
- TIMEOUT, 64, maximum EXEC cycles waiting for alu_done before an error is flagged.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-high reset.
- start  input  1  request to run an operation; sampled only when ready=1.
- op  input  2  00 single-width ALU op, 01 MUL, 10 DIV, 11 reserved.
- abort  input  1  synchronous abort; returns the FSM to IDLE from any state.
- ready  output  1  FSM is in IDLE and can accept start.
- busy  output  1  complement of ready.
- done  output  1  one-cycle pulse when the transfer completes.
- error  output  1  sticky error flag.
- alu_start  output  1  one-cycle pulse that launches the ALU.
- alu_op  output  2  latched op, held stable from acceptance until return to IDLE.
- alu_done  input  1  ALU result valid; the ALU holds its result until the next alu_start.
- ZIn  output  1  Z register write enable.
- ZLowSelect  output  1  capture the low half into Z.
- ZHighSelect  output  1  capture the high half into Z.
- ZLowOut  output  1  drive Z low half onto the bus.
- ZHighOut  output  1  drive Z high half onto the bus.
- LOin  output  1  LO register load.
- HIin  output  1  HI register load.
- Rin  output  1  destination general-register load (single-width ops).

Behaviour:
- States: IDLE, EXEC, CAP_LO, CAP_HI, XFER_LO, XFER_HI, DONE, ERR. One state per clock.
- All outputs are Moore, decoded from the state register or driven by registered flops. No combinational input-to-output paths.
- Reset (clr=1, async): state=IDLE, op latch=00, counter=0, error=0, ready=1. Every other output is 0.
- IDLE:
  - start=1 with op 00/01/10: latch op, clear error, go to EXEC.
  - start=1 with op 11: set error, stay in IDLE.
- EXEC:
  - alu_start=1 in the first EXEC cycle only.
  - The counter increments every EXEC cycle.
  - alu_done=1 leads to CAP_LO. The counter is cleared on exit.
  - If the counter reaches TIMEOUT-1 with alu_done=0, go to ERR.
  - alu_done has priority over timeout in the same cycle.
- CAP_LO: ZIn=1, ZLowSelect=1. Next state is CAP_HI for op 01/10, or XFER_LO for op 00.
- CAP_HI: ZIn=1, ZHighSelect=1, ZLowSelect=0. Next state is XFER_LO.
- XFER_LO: ZLowOut=1. Rin=1 if op=00, else LOin=1. Next state is XFER_HI for op 01/10, or DONE for op 00.
- XFER_HI: ZHighOut=1, HIin=1. Next state is DONE.
- DONE: done=1. Next state is IDLE.
- ERR: error=1, all datapath strobes 0. Stays in ERR until abort. error stays set in IDLE until the next accepted start.
- abort: from any non-IDLE state, go to IDLE next cycle with counter cleared.
  - No done pulse; in-flight Z contents are abandoned.
  - abort in ERR also clears error.
  - abort and start in the same IDLE cycle: abort wins, start is not accepted.
- start while busy is ignored, with no queuing.
- Mutual exclusion (assertable):
  - ZLowSelect and ZHighSelect are never both 1.
  - ZLowOut and ZHighOut are never both 1.
  - At most one of Rin/LOin/HIin is 1.
- Latency, with alu_done first seen in EXEC cycle T:
  - 64-bit op: done at T+5.
  - Single-width op: done at T+3.
- clr mid-operation: immediate IDLE and all strobes 0, even mid-capture.

Decomposition:
- Shared package: op encodings (OP_ALU=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_RSVD=2'b11) and the state enum. The control unit reuses both.
- One sub-module: seq_timeout_counter (CNT_W-bit counter with clear, increment-enable and terminal-count output).

Test Plan:
- Reset then op=01 start, alu_done after 5 EXEC cycles:
  - alu_start pulses once.
  - CAP_LO/CAP_HI/XFER_LO/XFER_HI occur on consecutive cycles.
  - done 5 cycles after alu_done.
  - Z-fed LO=0x0000_0002 and HI=0x0000_0001 when the ALU presents 0x00000001_00000002.
- op=00 start, alu_done in 1st EXEC cycle:
  - CAP_LO then XFER_LO with Rin=1, no HIin.
  - done at T+3.
  - ZHighSelect never asserted.
- op=10 with alu_done held low, TIMEOUT=64:
  - ERR entered after 64 EXEC cycles, error=1, no Z strobes.
  - abort leads to IDLE with error=0, ready=1.
- abort asserted during CAP_HI:
  - Next cycle IDLE, no done, no LOin/HIin.
  - A new start is accepted the following cycle.
- op=11 start:
  - error=1, FSM stays IDLE.
  - A subsequent valid start clears error and runs normally.
- clr asserted mid-XFER_LO (asynchronous, between edges):
  - All strobes 0 immediately, ready=1.
  - Same-cycle abort+start in IDLE is not accepted.

Source files
------------

// File: rtl/z_transfer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// z_transfer_sequencer_pkg
// Shared definitions for the Z-register transfer sequencer and the control
// unit that drives it: ALU operation encodings, sequencer state encoding and
// a helper that classifies 64-bit (LO/HI) operations.
// ---------------------------------------------------------------------------
package z_transfer_sequencer_pkg;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_CAP_LO  = 3'd2,
    S_CAP_HI  = 3'd3,
    S_XFER_LO = 3'd4,
    S_XFER_HI = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_e;

  // MUL and DIV produce a 64-bit result that is split into LO and HI.
  function automatic logic is_wide_op(input logic [1:0] op_i);
    return (op_i == OP_MUL) || (op_i == OP_DIV);
  endfunction

endpackage

// File: rtl/z_transfer_sequencer_timeout.sv
// ---------------------------------------------------------------------------
// seq_timeout_counter
// Counts cycles spent waiting for the ALU. Clear has priority over increment.
//   clk      : system clock, rising edge
//   clr      : asynchronous active-high reset
//   i_clear  : synchronous clear to zero
//   i_inc    : increment enable
//   o_count  : current count
//   o_tc     : count equals the terminal value TC
// ---------------------------------------------------------------------------
module seq_timeout_counter #(
  parameter int CNT_W = 7,
  parameter int TC    = 63
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] TC_V = CNT_W'(TC);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == TC_V);

endmodule

// File: rtl/z_transfer_sequencer.sv
// ---------------------------------------------------------------------------
// z_transfer_sequencer
// Runs one ALU operation and moves its result through the Z register:
// launches the ALU, waits for alu_done (bounded by TIMEOUT), captures the
// result into Z one half per cycle, then drives Z onto the bus into either
// the destination general register (single-width) or LO/HI (MUL/DIV).
// All outputs are decoded from registered state only.
//   clk, clr          : clock / asynchronous active-high reset
//   start, op, abort  : operation request, op code, synchronous abort
//   ready, busy       : IDLE indication and its complement
//   done, error       : completion pulse, sticky error flag
//   alu_start, alu_op : ALU launch pulse, latched op code
//   alu_done          : ALU result valid
//   ZIn, ZLowSelect, ZHighSelect : Z write enable and half select
//   ZLowOut, ZHighOut            : Z half bus drivers
//   LOin, HIin, Rin              : destination register loads
// ---------------------------------------------------------------------------
module z_transfer_sequencer
  import z_transfer_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       abort,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       alu_start,
  output logic [1:0] alu_op,
  input  logic       alu_done,
  output logic       ZIn,
  output logic       ZLowSelect,
  output logic       ZHighSelect,
  output logic       ZLowOut,
  output logic       ZHighOut,
  output logic       LOin,
  output logic       HIin,
  output logic       Rin
);

  state_e           r_state;
  state_e           w_state_next;
  logic [1:0]       r_op;
  logic             r_error;
  logic             w_accept;
  logic             w_err_set;
  logic             w_err_clr;
  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;
  logic             w_cnt_clear;
  logic             w_cnt_inc;
  logic             w_wide;

  assign w_wide = is_wide_op(r_op);

  // The counter runs only while in EXEC and is zeroed whenever EXEC is left,
  // so it always reads zero in the first EXEC cycle.
  assign w_cnt_inc   = (r_state == S_EXEC);
  assign w_cnt_clear = (w_state_next != S_EXEC);

  seq_timeout_counter #(
    .CNT_W (CNT_W),
    .TC    (TIMEOUT - 1)
  ) u_timeout (
    .clk     (clk),
    .clr     (clr),
    .i_clear (w_cnt_clear),
    .i_inc   (w_cnt_inc),
    .o_count (w_cnt),
    .o_tc    (w_tc)
  );

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Op latch and sticky error flag
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_op    <= OP_ALU;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= op;
      end
      if (w_err_set) begin
        r_error <= 1'b1;
      end else if (w_err_clr) begin
        r_error <= 1'b0;
      end
    end
  end

  // Next-state logic. Abort overrides everything, including a start
  // presented in the same IDLE cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_err_set    = 1'b0;
    w_err_clr    = 1'b0;
    if (abort) begin
      w_state_next = S_IDLE;
      w_err_clr    = (r_state == S_ERR);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_RSVD) begin
              w_err_set = 1'b1;
            end else begin
              w_accept     = 1'b1;
              w_err_clr    = 1'b1;
              w_state_next = S_EXEC;
            end
          end
        end
        S_EXEC: begin
          // alu_done wins over a timeout in the same cycle
          if (alu_done) begin
            w_state_next = S_CAP_LO;
          end else if (w_tc) begin
            w_state_next = S_ERR;
            w_err_set    = 1'b1;
          end
        end
        S_CAP_LO:  w_state_next = w_wide ? S_CAP_HI : S_XFER_LO;
        S_CAP_HI:  w_state_next = S_XFER_LO;
        S_XFER_LO: w_state_next = w_wide ? S_XFER_HI : S_DONE;
        S_XFER_HI: w_state_next = S_DONE;
        S_DONE:    w_state_next = S_IDLE;
        S_ERR:     w_state_next = S_ERR;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    ready       = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
    error       = r_error;
    alu_op      = r_op;
    done        = 1'b0;
    alu_start   = 1'b0;
    ZIn         = 1'b0;
    ZLowSelect  = 1'b0;
    ZHighSelect = 1'b0;
    ZLowOut     = 1'b0;
    ZHighOut    = 1'b0;
    LOin        = 1'b0;
    HIin        = 1'b0;
    Rin         = 1'b0;
    case (r_state)
      S_EXEC:    alu_start = (w_cnt == '0);
      S_CAP_LO: begin
        ZIn        = 1'b1;
        ZLowSelect = 1'b1;
      end
      S_CAP_HI: begin
        ZIn         = 1'b1;
        ZHighSelect = 1'b1;
      end
      S_XFER_LO: begin
        ZLowOut = 1'b1;
        Rin     = ~w_wide;
        LOin    = w_wide;
      end
      S_XFER_HI: begin
        ZHighOut = 1'b1;
        HIin     = 1'b1;
      end
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

endmodule
